// File: rtl/clkgen_rst_pkg.sv
// Shared definitions for the clock-generator reset sequencer:
// FSM state encoding, reset-cause bit positions and counter widths.
package clkgen_rst_pkg;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StStable   = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3,
    StSwHold   = 3'd4
  } state_e;

  localparam int unsigned CauseLockLoss = 0;
  localparam int unsigned CauseSw       = 1;
  localparam int unsigned LockLossCntW  = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing a slow asynchronous level into the clk_i domain.
// Asynchronous active-high reset to ResetValue.
module prim_flop_2sync #(
  parameter int unsigned           Width      = 1,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;

  // metastability-resolving flop pair
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/clkgen_rst_seq.sv
// Reset sequencer downstream of the clock generator: qualifies MMCM lock, releases
// thermometer-ordered resets with a fixed gap, and records why resets were re-asserted.
module clkgen_rst_seq
  import clkgen_rst_pkg::*;
#(
  parameter int unsigned NumStages        = 3,
  parameter int unsigned LockStableCycles = 1024,
  parameter int unsigned StageGapCycles   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pll_locked_i,
  input  logic                    sw_rst_req_i,
  input  logic                    cause_clr_i,
  output logic [NumStages-1:0]    rst_stage_no,
  output logic                    rst_done_o,
  output logic [1:0]              rst_cause_o,
  output logic [LockLossCntW-1:0] lock_loss_cnt_o
);

  localparam int unsigned CntMax = max_u(LockStableCycles, StageGapCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]         LockLast   = CntW'(LockStableCycles - 1);
  localparam logic [CntW-1:0]         GapLast    = CntW'(StageGapCycles - 1);
  localparam logic [NumStages-1:0]    StageFirst = NumStages'(1'b1);
  localparam logic [NumStages-1:0]    StageAll   = '1;
  localparam logic [LockLossCntW-1:0] LlcMax     = '1;

  logic                    lock_sync;
  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NumStages-1:0]    stage_q, stage_d;
  logic [NumStages-1:0]    stage_shift;
  logic                    done_q, done_d;
  logic [1:0]              cause_q, cause_d;
  logic [LockLossCntW-1:0] llc_q, llc_d;
  logic                    lock_loss_ev;
  logic                    sw_ev;

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (1'b0)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_sync)
  );

  // Shifting a one in from the bottom keeps the stage vector thermometer coded.
  assign stage_shift = (stage_q << 1'b1) | StageFirst;

  // sequencing FSM: next state, gap counter, stage vector and done flag
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CntW'(1);
    stage_d      = stage_q;
    done_d       = done_q;
    lock_loss_ev = 1'b0;
    sw_ev        = 1'b0;

    case (state_q)
      StWaitLock: begin
        cnt_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
        if (lock_sync) begin
          state_d = StStable;
        end else begin
          state_d = StWaitLock;
        end
      end

      StStable: begin
        if (!lock_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          cnt_d   = '0;
          stage_d = StageFirst;
          if (NumStages == 1) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          state_d = StStable;
        end
      end

      StRelease: begin
        if (!lock_sync) begin
          lock_loss_ev = 1'b1;
        end else if (cnt_q == GapLast) begin
          cnt_d   = '0;
          stage_d = stage_shift;
          if (stage_shift == StageAll) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          state_d = StRelease;
        end
      end

      StRun: begin
        cnt_d = '0;
        if (!lock_sync) begin
          lock_loss_ev = 1'b1;
        end else begin
          lock_loss_ev = 1'b0;
        end
        if (sw_rst_req_i) begin
          sw_ev = 1'b1;
        end else begin
          sw_ev = 1'b0;
        end
      end

      StSwHold: begin
        // Lock is only judged once the hold time has elapsed.
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (lock_sync) begin
            stage_d = StageFirst;
            if (NumStages == 1) begin
              state_d = StRun;
              done_d  = 1'b1;
            end else begin
              state_d = StRelease;
            end
          end else begin
            state_d = StWaitLock;
          end
        end else begin
          state_d = StSwHold;
        end
      end

      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase

    // Lock loss outranks a simultaneous software request for the next state.
    if (lock_loss_ev) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else if (sw_ev) begin
      state_d = StSwHold;
      cnt_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // sticky reset cause (a new cause beats the clear) and saturating lock-loss count
  always_comb begin
    cause_d = cause_q;
    llc_d   = llc_q;
    if (cause_clr_i) begin
      cause_d = 2'b00;
    end else begin
      cause_d = cause_q;
    end
    if (lock_loss_ev) begin
      cause_d[CauseLockLoss] = 1'b1;
      if (llc_q != LlcMax) begin
        llc_d = llc_q + LockLossCntW'(1);
      end else begin
        llc_d = llc_q;
      end
    end else begin
      llc_d = llc_q;
    end
    if (sw_ev) begin
      cause_d[CauseSw] = 1'b1;
    end else begin
      cause_d[CauseSw] = cause_d[CauseSw];
    end
  end

  // state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      llc_q   <= llc_d;
    end
  end

  assign rst_stage_no    = stage_q;
  assign rst_done_o      = done_q;
  assign rst_cause_o     = cause_q;
  assign lock_loss_cnt_o = llc_q;

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// Directed bench for clkgen_rst_seq (LockStableCycles=8, StageGapCycles=4, NumStages=3):
// expected output snapshots are queued with each step and popped when the step's cycles elapse.
module tb_clkgen_rst_seq;

  typedef struct {
    string      tag;
    logic [2:0] stage;
    logic       done;
    logic [1:0] cause;
    logic [7:0] llc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll;
  logic       sw;
  logic       clr;
  logic [2:0] stage;
  logic       done;
  logic [1:0] cause;
  logic [7:0] llc;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  clkgen_rst_seq #(
    .NumStages        (3),
    .LockStableCycles (8),
    .StageGapCycles   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pll_locked_i    (pll),
    .sw_rst_req_i    (sw),
    .cause_clr_i     (clr),
    .rst_stage_no    (stage),
    .rst_done_o      (done),
    .rst_cause_o     (cause),
    .lock_loss_cnt_o (llc)
  );

  always #5 clk = ~clk;

  // stage vector must stay thermometer coded, and done implies every stage released
  always @(negedge clk) begin
    logic [2:0] plus1;
    plus1 = stage + 3'd1;
    checks++;
    assert ((stage & plus1) === 3'd0)
      else begin errors++; $error("FAIL therm: observed %b expected thermometer code", stage); end
    checks++;
    assert ((done === 1'b0) || (stage === 3'b111))
      else begin errors++; $error("FAIL done_all: observed done=%b stage=%b expected stage 111", done, stage); end
  end

  task automatic check_front();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (stage === e.stage)
      else begin errors++; $error("FAIL %s stage: observed %b expected %b", e.tag, stage, e.stage); end
    checks++;
    assert (done === e.done)
      else begin errors++; $error("FAIL %s done: observed %b expected %b", e.tag, done, e.done); end
    checks++;
    assert (cause === e.cause)
      else begin errors++; $error("FAIL %s cause: observed %b expected %b", e.tag, cause, e.cause); end
    checks++;
    assert (llc === e.llc)
      else begin errors++; $error("FAIL %s llc: observed %0d expected %0d", e.tag, llc, e.llc); end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [2:0] st,
                              input logic dn, input logic [1:0] ca, input logic [7:0] lc);
    exp_t e;
    e.tag = tag; e.stage = st; e.done = dn; e.cause = ca; e.llc = lc;
    sb_q.push_back(e);
    repeat (n) @(negedge clk);
    check_front();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lock_loss_event();
    pll = 1'b1;
    tick(11);
    pll = 1'b0;
    tick(3);
  endtask

  initial begin
    rst = 1'b1; pll = 1'b1; sw = 1'b0; clr = 1'b0;
    tick(2);
    expect_after(0, "reset", 3'b000, 1'b0, 2'b00, 8'd0);

    // 1: power-up release with lock high from the start
    rst = 1'b0;
    expect_after(10, "t1_c10", 3'b000, 1'b0, 2'b00, 8'd0);
    expect_after(1,  "t1_c11", 3'b001, 1'b0, 2'b00, 8'd0);
    expect_after(3,  "t1_c14", 3'b001, 1'b0, 2'b00, 8'd0);
    expect_after(1,  "t1_c15", 3'b011, 1'b0, 2'b00, 8'd0);
    expect_after(3,  "t1_c18", 3'b011, 1'b0, 2'b00, 8'd0);
    expect_after(1,  "t1_c19", 3'b111, 1'b1, 2'b00, 8'd0);

    // 2: one-cycle lock glitch while Stable restarts qualification, not a lock loss
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(7);
    pll = 1'b0;
    tick(1);
    pll = 1'b1;
    expect_after(3, "t2_c11", 3'b000, 1'b0, 2'b00, 8'd0);
    expect_after(7, "t2_c18", 3'b000, 1'b0, 2'b00, 8'd0);
    expect_after(1, "t2_c19", 3'b001, 1'b0, 2'b00, 8'd0);
    expect_after(8, "t2_c27", 3'b111, 1'b1, 2'b00, 8'd0);

    // 3: lock loss in Run
    pll = 1'b0;
    expect_after(2, "t3_drop2", 3'b111, 1'b1, 2'b00, 8'd0);
    expect_after(1, "t3_drop3", 3'b000, 1'b0, 2'b01, 8'd1);
    tick(2);
    pll = 1'b1;
    expect_after(10, "t3_c10", 3'b000, 1'b0, 2'b01, 8'd1);
    expect_after(1,  "t3_c11", 3'b001, 1'b0, 2'b01, 8'd1);
    expect_after(4,  "t3_c15", 3'b011, 1'b0, 2'b01, 8'd1);
    expect_after(4,  "t3_c19", 3'b111, 1'b1, 2'b01, 8'd1);

    // 4: cause clear, then software reset in Run; a request during Release is ignored
    clr = 1'b1;
    expect_after(1, "t4_clr", 3'b111, 1'b1, 2'b00, 8'd1);
    clr = 1'b0;
    sw = 1'b1;
    expect_after(1, "t4_sw1", 3'b000, 1'b0, 2'b10, 8'd1);
    sw = 1'b0;
    expect_after(3, "t4_sw4", 3'b000, 1'b0, 2'b10, 8'd1);
    expect_after(1, "t4_sw5", 3'b001, 1'b0, 2'b10, 8'd1);
    sw = 1'b1;
    expect_after(1, "t4_ign", 3'b001, 1'b0, 2'b10, 8'd1);
    sw = 1'b0;
    expect_after(3, "t4_sw9",  3'b011, 1'b0, 2'b10, 8'd1);
    expect_after(3, "t4_sw12", 3'b011, 1'b0, 2'b10, 8'd1);
    expect_after(1, "t4_sw13", 3'b111, 1'b1, 2'b10, 8'd1);

    // 5: 300 lock losses saturate the counter; a cause set beats a same-cycle clear
    for (int i = 0; i < 253; i++) lock_loss_event();
    expect_after(0, "t5_254", 3'b000, 1'b0, 2'b11, 8'd254);
    lock_loss_event();
    expect_after(0, "t5_255", 3'b000, 1'b0, 2'b11, 8'd255);
    for (int i = 0; i < 46; i++) lock_loss_event();
    expect_after(0, "t5_sat", 3'b000, 1'b0, 2'b11, 8'd255);
    pll = 1'b1;
    expect_after(11, "t5_rel", 3'b001, 1'b0, 2'b11, 8'd255);
    pll = 1'b0;
    tick(2);
    clr = 1'b1;
    expect_after(1, "t5_clrwin", 3'b000, 1'b0, 2'b01, 8'd255);
    clr = 1'b0;

    // 6: asynchronous reset in the middle of Release
    pll = 1'b1;
    expect_after(15, "t6_c15", 3'b011, 1'b0, 2'b01, 8'd255);
    tick(1);
    rst = 1'b1;
    #1;
    expect_after(0, "t6_async", 3'b000, 1'b0, 2'b00, 8'd0);
    tick(2);
    rst = 1'b0;
    expect_after(11, "t6_c11", 3'b001, 1'b0, 2'b00, 8'd0);
    expect_after(8,  "t6_c19", 3'b111, 1'b1, 2'b00, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
